// File: rtl/wm8731_i2c_cmd_sched_pkg.sv
// -----------------------------------------------------------------------------
// wm8731_i2c_cmd_sched_pkg
// Shared definitions for the WM8731 I2C command scheduler:
//   - state_t          : scheduler FSM state encoding
//   - DEV_ADDR_DEFAULT : WM8731 write address (CSB low)
//   - make_frame()     : builds the 24-bit {dev, byte2, byte3} I2C frame from a
//                        requester slice {reg_addr[6:0], reg_data[8:0]}
// -----------------------------------------------------------------------------
package wm8731_i2c_cmd_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic [7:0] DEV_ADDR_DEFAULT = 8'h34;
    localparam int         SLICE_W          = 16;
    localparam int         FRAME_W          = 24;

    // byte2 = {reg_addr[6:0], reg_data[8]}, byte3 = reg_data[7:0]; the device
    // address R/W bit is always forced to write.
    function automatic logic [FRAME_W-1:0] make_frame(input logic [7:0]         dev,
                                                      input logic [SLICE_W-1:0] slice);
        return {dev[7:1], 1'b0, slice[15:9], slice[8], slice[7:0]};
    endfunction

endpackage

// File: rtl/wm8731_i2c_cmd_sched_if.sv
// -----------------------------------------------------------------------------
// wm8731_i2c_cmd_sched_if
// Bundles the requester handshake and the I2C engine handshake of the command
// scheduler.
//   req_valid/req_data/req_ready : requester write requests (valid/ready)
//   resp_done/resp_err           : per-requester completion pulse + error flag
//   i2c_req/i2c_wdata            : frame start pulse and frame to the engine
//   i2c_busy/i2c_done/i2c_nack   : engine status
// Modports: master = scheduler side, slave = requesters + engine side.
// -----------------------------------------------------------------------------
interface wm8731_i2c_cmd_sched_if
    import wm8731_i2c_cmd_sched_pkg::*;
#(
    parameter int NREQ = 3
) ();
    logic [NREQ-1:0]         req_valid;
    logic [SLICE_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0]         resp_done;
    logic [NREQ-1:0]         resp_err;
    logic                    i2c_req;
    logic [FRAME_W-1:0]      i2c_wdata;
    logic                    i2c_busy;
    logic                    i2c_done;
    logic                    i2c_nack;

    modport master (
        input  req_valid, req_data, i2c_busy, i2c_done, i2c_nack,
        output req_ready, resp_done, resp_err, i2c_req, i2c_wdata
    );

    modport slave (
        output req_valid, req_data, i2c_busy, i2c_done, i2c_nack,
        input  req_ready, resp_done, resp_err, i2c_req, i2c_wdata
    );
endinterface

// File: rtl/wm8731_i2c_cmd_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wm8731_i2c_cmd_sched_rr_arbiter
// Combinational round-robin pick: first requester with i_req set at or after
// i_ptr, wrapping at NREQ.
//   i_req   in  NREQ   request vector
//   i_ptr   in  IDX_W  highest-priority index (must be < NREQ)
//   o_grant out NREQ   onehot grant (0 when no request)
//   o_idx   out IDX_W  index of the granted requester
//   o_any   out 1      at least one request present
// -----------------------------------------------------------------------------
module wm8731_i2c_cmd_sched_rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);
    logic [IDX_W-1:0] w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = IDX_W'((int'(i_ptr) + k) % NREQ);
            if (!o_any && i_req[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
            end
        end
    end
endmodule

// File: rtl/wm8731_i2c_cmd_sched.sv
// -----------------------------------------------------------------------------
// wm8731_i2c_cmd_sched
// Shares one I2C write engine between NREQ requesters. Round-robin grants one
// WM8731 register write at a time, formats the 24-bit frame, issues it,
// re-issues on NACK after RETRY_GAP idle cycles (up to MAX_RETRY times), aborts
// after TIMEOUT cycles without i2c_done, and returns done/err to the requester.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : wm8731_i2c_cmd_sched_if.master (requester + engine handshakes)
//   sched_busy  : scheduler not idle
//   err_cnt     : saturating count of error responses
// -----------------------------------------------------------------------------
module wm8731_i2c_cmd_sched
    import wm8731_i2c_cmd_sched_pkg::*;
#(
    parameter int         NREQ      = 3,
    parameter logic [7:0] DEV_ADDR  = DEV_ADDR_DEFAULT,
    parameter int         MAX_RETRY = 3,
    parameter int         RETRY_GAP = 1000,
    parameter int         TIMEOUT   = 2_000_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    wm8731_i2c_cmd_sched_if.master       bus,
    output logic                         sched_busy,
    output logic [7:0]                   err_cnt
);
    localparam int          IDX_W     = $clog2(NREQ);
    localparam logic [31:0] TMO_LOAD  = 32'(TIMEOUT - 1);
    localparam logic [31:0] GAP_LOAD  = 32'(RETRY_GAP - 1);
    localparam logic [31:0] RETRY_MAX = 32'(MAX_RETRY);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
        return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t               r_state;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_gidx;
    logic [FRAME_W-1:0]   r_i2c_wdata;
    logic [NREQ-1:0]      r_resp_done;
    logic [NREQ-1:0]      r_resp_err;
    logic                 r_err;
    logic [7:0]           r_err_cnt;
    logic [31:0]          r_tmo_cnt;
    logic [31:0]          r_gap_cnt;
    logic [31:0]          r_retry_cnt;

    logic [NREQ-1:0]      w_grant;
    logic [IDX_W-1:0]     w_gidx;
    logic                 w_any;
    logic                 w_accept;
    logic [SLICE_W-1:0]   w_slice;

    wm8731_i2c_cmd_sched_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    // Slice of the granted requester, picked with constant part-selects.
    always_comb begin
        w_slice = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gidx == IDX_W'(i)) begin
                w_slice = bus.req_data[i*SLICE_W +: SLICE_W];
            end
        end
    end

    assign w_accept      = (r_state == ST_IDLE) && w_any;
    assign bus.req_ready = (r_state == ST_IDLE) ? w_grant : '0;
    // Decoded from state so the frame starts in the first ISSUE cycle the
    // engine is free (accept at cycle 0 -> i2c_req at cycle 1).
    assign bus.i2c_req   = (r_state == ST_ISSUE) && !bus.i2c_busy;
    assign bus.i2c_wdata = r_i2c_wdata;
    assign bus.resp_done = r_resp_done;
    assign bus.resp_err  = r_resp_err;
    assign sched_busy    = (r_state != ST_IDLE);
    assign err_cnt       = r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gidx      <= '0;
            r_i2c_wdata <= '0;
            r_resp_done <= '0;
            r_resp_err  <= '0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_retry_cnt <= '0;
        end else begin
            r_resp_done <= '0;
            r_resp_err  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_gidx      <= w_gidx;
                        r_i2c_wdata <= make_frame(DEV_ADDR, w_slice);
                        r_retry_cnt <= '0;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!bus.i2c_busy) begin
                        r_tmo_cnt <= TMO_LOAD;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // i2c_done is checked first so a done on the expiry cycle wins.
                    if (bus.i2c_done) begin
                        if (!bus.i2c_nack) begin
                            r_err       <= 1'b0;
                            r_resp_done <= onehot(r_gidx);
                            r_state     <= ST_RESP;
                        end else if (r_retry_cnt < RETRY_MAX) begin
                            r_retry_cnt <= r_retry_cnt + 32'd1;
                            r_gap_cnt   <= GAP_LOAD;
                            r_state     <= ST_GAP;
                        end else begin
                            r_err       <= 1'b1;
                            r_resp_done <= onehot(r_gidx);
                            r_resp_err  <= onehot(r_gidx);
                            r_state     <= ST_RESP;
                        end
                    end else if (r_tmo_cnt == '0) begin
                        r_err       <= 1'b1;
                        r_resp_done <= onehot(r_gidx);
                        r_resp_err  <= onehot(r_gidx);
                        r_state     <= ST_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt - 32'd1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= ST_ISSUE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 32'd1;
                    end
                end
                ST_RESP: begin
                    r_err_cnt <= sat_inc8(r_err_cnt, r_err);
                    r_ptr     <= (r_gidx == IDX_W'(NREQ - 1)) ? '0 : r_gidx + 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
